// File: rtl/sample_frame_buffer_pkg.sv
// Shared constants and FSM encoding for the plot sample frame buffer.
// Imported by the buffer and by the VGA plot renderer.
package sample_frame_buffer_pkg;

  localparam int NUM_SAMPLES = 300;
  localparam int DATA_W      = 4;
  localparam int MAX_VAL     = 9;
  localparam int IDX_W       = 9;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/sample_frame_buffer_ram.sv
// sample_bank_ram: 1-write/1-read synchronous RAM, registered read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read, latency 1).
module sample_bank_ram #(
  parameter int DEPTH = 300,
  parameter int WIDTH = 4,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range reads return 0 instead of indexing past the array.
  always_ff @(posedge clk) begin
    if (32'(raddr) < DEPTH) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/sample_frame_buffer.sv
// Double-buffered plot sample store: producer fills the back bank over
// valid/ready, renderer reads the front bank; banks swap on frame_sync.
// Ports: CLK100MHZ, rst (async, active high), in_valid/in_ready/in_data,
//   frame_sync, rd_index -> rd_data (latency 1), frame_valid, frame_count.
// Build option: SAMPLE_CLAMP_EN clamps samples above MAX_VAL to MAX_VAL.
module sample_frame_buffer
  import sample_frame_buffer_pkg::state_t;
  import sample_frame_buffer_pkg::FILL;
  import sample_frame_buffer_pkg::FULL;
#(
  parameter int NUM_SAMPLES = 300,
  parameter int DATA_W      = 4,
  parameter int MAX_VAL     = 9,
  parameter int IDX_W       = 9
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              frame_sync,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic [7:0]        frame_count
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SAMPLES - 1);

  state_t             state;
  state_t             state_d;
  logic [IDX_W-1:0]   wr_ptr;
  logic [IDX_W-1:0]   ptr_d;
  logic               front_sel;
  logic               sel_d;
  logic               fv_d;
  logic [7:0]         cnt_d;
  logic               xfer;
  logic [DATA_W-1:0]  wdata;
  logic               we0;
  logic               we1;
  logic [DATA_W-1:0]  rdata0;
  logic [DATA_W-1:0]  rdata1;
  logic               rd_sel_q;
  logic               rd_ok_q;

  assign xfer = in_valid && in_ready;

`ifdef SAMPLE_CLAMP_EN
  assign wdata = (in_data > DATA_W'(MAX_VAL)) ? DATA_W'(MAX_VAL) : in_data;
`else
  assign wdata = in_data;
`endif

  // front_sel names the bank being displayed; writes go to the other.
  assign we0 = xfer && front_sel;
  assign we1 = xfer && !front_sel;

  sample_bank_ram #(
    .DEPTH (NUM_SAMPLES),
    .WIDTH (DATA_W),
    .AW    (IDX_W)
  ) u_bank0 (
    .clk   (CLK100MHZ),
    .we    (we0),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_index),
    .rdata (rdata0)
  );

  sample_bank_ram #(
    .DEPTH (NUM_SAMPLES),
    .WIDTH (DATA_W),
    .AW    (IDX_W)
  ) u_bank1 (
    .clk   (CLK100MHZ),
    .we    (we1),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_index),
    .rdata (rdata1)
  );

  always_comb begin
    state_d = state;
    ptr_d   = wr_ptr;
    sel_d   = front_sel;
    fv_d    = frame_valid;
    cnt_d   = frame_count;
    unique case (1'b1)
      (state == FILL): begin
        if (xfer) begin
          if (wr_ptr == LAST) begin
            ptr_d   = '0;
            state_d = FULL;
          end else begin
            ptr_d = wr_ptr + 1'b1;
          end
        end
      end
      (state == FULL): begin
        if (frame_sync) begin
          sel_d   = !front_sel;
          fv_d    = 1'b1;
          cnt_d   = frame_count + 8'd1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // in_ready is registered from the next state so it stays low in reset
  // and rises on the first edge after reset releases.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      wr_ptr      <= '0;
      front_sel   <= 1'b0;
      frame_valid <= 1'b0;
      frame_count <= 8'd0;
      in_ready    <= 1'b0;
    end else begin
      state       <= state_d;
      wr_ptr      <= ptr_d;
      front_sel   <= sel_d;
      frame_valid <= fv_d;
      frame_count <= cnt_d;
      in_ready    <= (state_d == FILL);
    end
  end

  // Bank select and masking travel alongside the RAM read so a swap
  // applies to reads issued after the sync edge.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      rd_sel_q <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      rd_sel_q <= front_sel;
      rd_ok_q  <= frame_valid && (32'(rd_index) < NUM_SAMPLES);
    end
  end

  assign rd_data = !rd_ok_q  ? '0 :
                   rd_sel_q  ? rdata1 : rdata0;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Self-checking bench for sample_frame_buffer: directed read vectors
// plus hand-written fill/swap/reset sequences.
module tb_sample_frame_buffer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       frame_sync;
  logic [8:0] rd_index;
  logic [3:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_count;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [8:0] idx;
    logic [3:0] exp;
  } vec_t;

  vec_t vt [12];

  sample_frame_buffer dut (
    .CLK100MHZ   (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .frame_sync  (frame_sync),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // kind < 0 streams i%10, otherwise the constant kind.
  // pause_at >= 0 inserts a 20-cycle idle gap with a stray frame_sync.
  task automatic fill(input int n, input int kind,
                      input int pause_at, input bit sync_last);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
          frame_sync = (k == 10);
          step();
        end
        frame_sync = 1'b0;
        chk("pause_ready", int'(in_ready), 1);
        chk("pause_count", int'(frame_count), 0);
        chk("pause_fv", int'(frame_valid), 0);
      end
      chk("fill_ready", int'(in_ready), 1);
      in_valid   = 1'b1;
      in_data    = (kind < 0) ? 4'(i % 10) : 4'(kind);
      frame_sync = sync_last && (i == n - 1);
      step();
    end
    in_valid   = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
  endtask

  task automatic rd(input int idx, input int exp, input string nm);
    rd_index = 9'(idx);
    step();
    chk(nm, int'(rd_data), exp);
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < 12; i++) begin
      rd_index = vt[i].idx;
      step();
      chk(nm, int'(rd_data), int'(vt[i].exp));
    end
  endtask

  int clamp_exp;

  initial begin
    n_chk  = 0;
    n_fail = 0;
`ifdef SAMPLE_CLAMP_EN
    clamp_exp = 9;
`else
    clamp_exp = 15;
`endif
    vt[0]  = '{9'd0,   4'd0};
    vt[1]  = '{9'd1,   4'd1};
    vt[2]  = '{9'd9,   4'd9};
    vt[3]  = '{9'd10,  4'd0};
    vt[4]  = '{9'd123, 4'd3};
    vt[5]  = '{9'd149, 4'd9};
    vt[6]  = '{9'd150, 4'd0};
    vt[7]  = '{9'd151, 4'd1};
    vt[8]  = '{9'd298, 4'd8};
    vt[9]  = '{9'd299, 4'd9};
    vt[10] = '{9'd300, 4'd0};
    vt[11] = '{9'd511, 4'd0};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    frame_sync = 1'b0;
    rd_index   = '0;
    step();
    step();
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_rd", int'(rd_data), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_count", int'(frame_count), 0);

    rst      = 1'b0;
    rd_index = 9'd5;
    step();
    chk("first_ready", int'(in_ready), 1);
    chk("first_rd", int'(rd_data), 0);
    chk("first_fv", int'(frame_valid), 0);

    // Frame A: i%10 with a gap and a stray sync mid-fill.
    fill(300, -1, 150, 1'b0);
    chk("a_full_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 4'd4;
    step();
    step();
    in_valid = 1'b0;
    chk("a_hold_ready", int'(in_ready), 0);
    chk("a_hold_count", int'(frame_count), 0);
    pulse_sync();
    chk("a_fv", int'(frame_valid), 1);
    chk("a_count", int'(frame_count), 1);
    chk("a_ready", int'(in_ready), 1);
    rd(123, 3, "a_rd123");
    run_table("a_table");

    // Frame B: all 7s while A stays on display.
    fill(300, 7, -1, 1'b0);
    chk("b_full_ready", int'(in_ready), 0);
    run_table("b_pre_table");
    rd_index   = 9'd123;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    chk("b_sync_rd_old", int'(rd_data), 3);
    chk("b_count", int'(frame_count), 2);
    rd(123, 7, "b_rd123");
    rd(300, 0, "b_rd300");
    rd(0, 7, "b_rd0");
    rd(299, 7, "b_rd299");

    // Frame C: sync coincides with the last transfer and is ignored.
    fill(300, 5, -1, 1'b1);
    chk("c_ready", int'(in_ready), 0);
    chk("c_count_hold", int'(frame_count), 2);
    rd(10, 7, "c_rd_old");
    pulse_sync();
    chk("c_count", int'(frame_count), 3);
    rd(10, 5, "c_rd_new");
    rd(299, 5, "c_rd299");

    // Frame D: out-of-range samples.
    fill(300, 15, -1, 1'b0);
    pulse_sync();
    chk("d_count", int'(frame_count), 4);
    rd(0, clamp_exp, "d_rd0");
    rd(299, clamp_exp, "d_rd299");

    // Reset mid-fill discards the partial frame.
    fill(100, -1, -1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_ready", int'(in_ready), 0);
    chk("mrst_rd", int'(rd_data), 0);
    chk("mrst_fv", int'(frame_valid), 0);
    chk("mrst_count", int'(frame_count), 0);
    step();
    rst = 1'b0;
    step();
    chk("mrst_ready_up", int'(in_ready), 1);
    fill(300, 2, -1, 1'b0);
    chk("e_full_ready", int'(in_ready), 0);
    pulse_sync();
    chk("e_count", int'(frame_count), 1);
    chk("e_fv", int'(frame_valid), 1);
    rd(0, 2, "e_rd0");
    rd(299, 2, "e_rd299");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
